// File: rtl/reloj_pkg.sv
// Shared types, limits and BCD helpers for the reloj_hms time-of-day clock.
// All time values are packed two-digit BCD {tens[7:4], units[3:0]}.
package reloj_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEG_MAX = 8'h59;
  localparam bcd2_t MIN_MAX = 8'h59;
  localparam bcd2_t H24_MAX = 8'h23;
  localparam bcd2_t H12_MAX = 8'h12;
  localparam bcd2_t H12_MIN = 8'h01;

  // Both nibbles are decimal digits.
  function automatic logic bcd_valid(input bcd2_t v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // BCD +1 without wrap handling; callers wrap at their own modulus first.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Re-express an hour when the display mode flips. The pm flag is not
  // changed by a conversion: it already equals (hour >= 12) in 24 h mode.
  //   to24 = 1 : 12 h value + pm -> 00..23
  //   to24 = 0 : 00..23          -> 12 h value
  function automatic bcd2_t hour_convert(input bcd2_t h, input logic pm, input logic to24);
    bcd2_t r;
    r = h;
    if (to24) begin
      if (h == H12_MAX) begin
        r = pm ? H12_MAX : 8'h00;
      end else if (pm) begin
        // h + 12 in BCD, h in 01..11
        if (h[3:0] >= 4'd8) begin
          r = {h[7:4] + 4'd2, h[3:0] - 4'd8};
        end else begin
          r = {h[7:4] + 4'd1, h[3:0] + 4'd2};
        end
      end
    end else begin
      if (h == 8'h00) begin
        r = H12_MAX;
      end else if (h > H12_MAX) begin
        // h - 12 in BCD, h in 13..23
        if (h[3:0] >= 4'd2) begin
          r = {h[7:4] - 4'd1, h[3:0] - 4'd2};
        end else begin
          r = {h[7:4] - 4'd2, h[3:0] + 4'd8};
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reloj_bcd_digito.sv
// Two-digit BCD modulo counter (00..MAX) used for seconds and minutes.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset (-> 00)
//   inc             advance by one, wrapping MAX -> 00
//   load, load_val  synchronous load, takes priority over inc
//   value           current count, packed BCD (registered)
//   carry           inc while value == MAX; feeds the next stage's inc
module reloj_bcd_digito
  import reloj_pkg::*;
#(
  parameter logic [7:0] MAX = SEG_MAX
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      value_d = (value_q == MAX) ? 8'h00 : bcd_inc(value_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && (value_q == MAX);

endmodule

// File: rtl/reloj_hms.sv
// Time-of-day clock: divides the system clock to 1 Hz and keeps seconds,
// minutes and hours in packed BCD, with runtime 12 h / 24 h display mode,
// AM/PM tracking and a validated synchronous time-load port.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   run                     1 = prescaler advances, 0 = time frozen
//   modo24                  requested display mode (1 = 24 h)
//   ajust                   load strobe
//   ajust_seg/min/hora      BCD load values; ajust_pm used only in 12 h mode
//   seg, min, hora, pm      current time (registered)
//   segundo                 1 Hz square wave, high for the first half-second
//   tick_min                one-cycle pulse when seconds wrap 59 -> 00
//   ajust_err               one-cycle pulse after a rejected load
// CLK_DIV must be even and >= 2.
module reloj_hms
  import reloj_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       modo24,
  input  logic       ajust,
  input  logic [7:0] ajust_seg,
  input  logic [7:0] ajust_min,
  input  logic [7:0] ajust_hora,
  input  logic       ajust_pm,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic       pm,
  output logic       segundo,
  output logic       tick_min,
  output logic       ajust_err
);

  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_DIV / 2);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hora_q, hora_d;
  logic          pm_q, pm_d;
  logic          mode_q, mode_d;
  logic          segundo_q, segundo_d;
  logic          tick_min_q;
  logic          err_q;

  logic          fmt_ok, hour_ok, load_ok;
  logic          conv, wrap, tick;
  logic          seg_carry, min_carry;

  // ---------------------------------------------------------------------------
  // Load validation, checked against the mode requested this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    fmt_ok = bcd_valid(ajust_seg) && bcd_valid(ajust_min) && bcd_valid(ajust_hora) &&
             (ajust_seg <= SEG_MAX) && (ajust_min <= MIN_MAX);
    if (modo24) begin
      hour_ok = (ajust_hora <= H24_MAX);
    end else begin
      hour_ok = (ajust_hora >= H12_MIN) && (ajust_hora <= H12_MAX);
    end
  end

  assign load_ok = ajust && fmt_ok && hour_ok;
  // A valid load sets the mode itself, so it suppresses conversion.
  assign conv    = !load_ok && (modo24 != mode_q);
  assign wrap    = run && (presc_q == PRESC_LAST);
  // Load discards the tick; conversion defers it by holding the prescaler.
  assign tick    = wrap && !load_ok && !conv;

  // ---------------------------------------------------------------------------
  // Prescaler and 1 Hz square wave
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q;
    if (load_ok) begin
      presc_d = '0;
    end else if (run) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = conv ? presc_q : '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // segundo tracks the prescaler value it is registered alongside; it only
    // moves when the prescaler is actually written, so it holds while frozen.
    segundo_d = segundo_q;
    if (run || load_ok) begin
      segundo_d = (presc_d < PRESC_HALF);
    end
  end

  // ---------------------------------------------------------------------------
  // Seconds and minutes
  // ---------------------------------------------------------------------------
  reloj_bcd_digito #(
    .MAX (SEG_MAX)
  ) u_seg (
    .clock    (clock),
    .reset    (reset),
    .inc      (tick),
    .load     (load_ok),
    .load_val (ajust_seg),
    .value    (seg),
    .carry    (seg_carry)
  );

  reloj_bcd_digito #(
    .MAX (MIN_MAX)
  ) u_min (
    .clock    (clock),
    .reset    (reset),
    .inc      (seg_carry),
    .load     (load_ok),
    .load_val (ajust_min),
    .value    (min),
    .carry    (min_carry)
  );

  // ---------------------------------------------------------------------------
  // Hours, pm and mode register
  // ---------------------------------------------------------------------------
  always_comb begin
    hora_d = hora_q;
    pm_d   = pm_q;
    mode_d = mode_q;
    if (load_ok) begin
      hora_d = ajust_hora;
      mode_d = modo24;
      pm_d   = modo24 ? (ajust_hora >= H12_MAX) : ajust_pm;
    end else if (conv) begin
      hora_d = hour_convert(hora_q, pm_q, modo24);
      mode_d = modo24;
    end else if (min_carry) begin
      if (mode_q) begin
        hora_d = (hora_q == H24_MAX) ? 8'h00 : bcd_inc(hora_q);
        pm_d   = (hora_d >= H12_MAX);
      end else if (hora_q == H12_MAX) begin
        // 12 -> 01 leaves pm alone
        hora_d = H12_MIN;
      end else begin
        hora_d = bcd_inc(hora_q);
        if (hora_q == 8'h11) begin
          pm_d = !pm_q;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q    <= '0;
      hora_q     <= modo24 ? 8'h00 : H12_MAX;
      pm_q       <= 1'b0;
      mode_q     <= modo24;
      segundo_q  <= 1'b0;
      tick_min_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hora_q     <= hora_d;
      pm_q       <= pm_d;
      mode_q     <= mode_d;
      segundo_q  <= segundo_d;
      tick_min_q <= seg_carry;
      err_q      <= ajust && !load_ok;
    end
  end

  assign hora      = hora_q;
  assign pm        = pm_q;
  assign segundo   = segundo_q;
  assign tick_min  = tick_min_q;
  assign ajust_err = err_q;

endmodule

// File: tb/tb_reloj_hms.sv
// Bench for reloj_hms at CLK_DIV = 4. A reference model keeps the time as
// seconds-of-day plus a display mode and is compared against every output
// after every edge; directed scenarios add fixed-value checks on top.
module tb_reloj_hms;

  localparam int unsigned CLK_DIV = 4;

  logic       clock = 1'b0;
  logic       reset, run, modo24, ajust, ajust_pm;
  logic [7:0] ajust_seg, ajust_min, ajust_hora;
  logic [7:0] seg, min, hora;
  logic       pm, segundo, tick_min, ajust_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tm_cnt  = 0;

  // reference model state
  int m_tod;   // seconds since midnight
  bit m_mode;  // 1 = 24 h display
  int m_p;     // prescaler count
  bit m_sg, m_tm, m_err;

  reloj_hms #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .modo24     (modo24),
    .ajust      (ajust),
    .ajust_seg  (ajust_seg),
    .ajust_min  (ajust_min),
    .ajust_hora (ajust_hora),
    .ajust_pm   (ajust_pm),
    .seg        (seg),
    .min        (min),
    .hora       (hora),
    .pm         (pm),
    .segundo    (segundo),
    .tick_min   (tick_min),
    .ajust_err  (ajust_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit load_valid(input logic [7:0] s, input logic [7:0] mi,
                                    input logic [7:0] h, input bit m24);
    if (s[7:4] > 9 || s[3:0] > 9 || mi[7:4] > 9 || mi[3:0] > 9 || h[7:4] > 9 || h[3:0] > 9)
      return 1'b0;
    if (from_bcd(s) > 59 || from_bcd(mi) > 59) return 1'b0;
    if (m24) return from_bcd(h) <= 23;
    return (from_bcd(h) >= 1) && (from_bcd(h) <= 12);
  endfunction

  // Advance the model by one rising edge using the inputs the DUT sampled.
  task automatic model_edge();
    bit ld, conv, tick;
    int h;
    if (reset) begin
      m_tod = 0; m_mode = modo24; m_p = 0; m_sg = 0; m_tm = 0; m_err = 0;
    end else begin
      ld    = ajust && load_valid(ajust_seg, ajust_min, ajust_hora, modo24);
      m_err = ajust && !ld;
      conv  = !ld && (modo24 != m_mode);
      tick  = run && (m_p == CLK_DIV - 1) && !ld && !conv;
      if (ld) begin
        h = from_bcd(ajust_hora);
        if (!modo24) h = (h == 12) ? (ajust_pm ? 12 : 0) : (ajust_pm ? h + 12 : h);
        m_tod  = h * 3600 + from_bcd(ajust_min) * 60 + from_bcd(ajust_seg);
        m_mode = modo24;
        m_p    = 0;
      end else begin
        if (conv) m_mode = modo24;
        if (run) m_p = (m_p == CLK_DIV - 1) ? (conv ? m_p : 0) : m_p + 1;
      end
      if (tick) m_tod = (m_tod + 1) % 86400;
      m_tm = tick && (m_tod % 60 == 0);
      if (run || ld) m_sg = (m_p < CLK_DIV / 2);
    end
  endtask

  task automatic check_model();
    int h24, h12;
    h24 = m_tod / 3600;
    h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
    check_eq("seg", 32'(seg), 32'(to_bcd(m_tod % 60)));
    check_eq("min", 32'(min), 32'(to_bcd((m_tod / 60) % 60)));
    check_eq("hora", 32'(hora), 32'(m_mode ? to_bcd(h24) : to_bcd(h12)));
    check_eq("pm", 32'(pm), 32'(h24 >= 12));
    check_eq("segundo", 32'(segundo), 32'(m_sg));
    check_eq("tick_min", 32'(tick_min), 32'(m_tm));
    check_eq("ajust_err", 32'(ajust_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    if (tick_min) tm_cnt++;
    check_model();
  endtask

  task automatic set_load(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                          input logic p);
    ajust = 1'b1; ajust_hora = h; ajust_min = mi; ajust_seg = s; ajust_pm = p;
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] mi,
                            input logic [7:0] s, input logic p);
    check_eq({tag, "_hora"}, 32'(hora), 32'(h));
    check_eq({tag, "_min"}, 32'(min), 32'(mi));
    check_eq({tag, "_seg"}, 32'(seg), 32'(s));
    check_eq({tag, "_pm"}, 32'(pm), 32'(p));
  endtask

  initial begin
    logic [7:0] sq;
    reset = 1'b1; run = 1'b1; modo24 = 1'b0; ajust = 1'b0; ajust_pm = 1'b0;
    ajust_seg = 8'h00; ajust_min = 8'h00; ajust_hora = 8'h00;
    step(); step();
    check_time("rst12", 8'h12, 8'h00, 8'h00, 1'b0);
    check_eq("rst_segundo", 32'(segundo), 32'd0);
    reset = 1'b0;

    // free run from reset: seg 01 on 4th edge, 02 on 8th
    sq = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      sq[i] = segundo;
      if (i == 3) check_eq("first_tick_seg", 32'(seg), 32'h01);
    end
    check_eq("segundo_pattern", 32'(sq), 32'h99);
    check_time("run8", 8'h12, 8'h00, 8'h02, 1'b0);

    // 24 h full cascade
    modo24 = 1'b1;
    set_load(8'h23, 8'h59, 8'h58, 1'b0);
    step();
    ajust = 1'b0;
    check_time("ld24", 8'h23, 8'h59, 8'h58, 1'b1);
    tm_cnt = 0;
    repeat (4) step();
    check_time("pre_wrap", 8'h23, 8'h59, 8'h59, 1'b1);
    repeat (4) step();
    check_time("midnight", 8'h00, 8'h00, 8'h00, 1'b0);
    check_eq("tick_min_hi", 32'(tick_min), 32'd1);
    step();
    check_eq("tick_min_cnt", 32'(tm_cnt), 32'd1);

    // 12 h: 11 -> 12 toggles pm, 12 -> 01 does not
    modo24 = 1'b0;
    set_load(8'h11, 8'h59, 8'h59, 1'b0);
    step();
    ajust = 1'b0;
    repeat (4) step();
    check_time("noon", 8'h12, 8'h00, 8'h00, 1'b1);
    set_load(8'h12, 8'h59, 8'h59, 1'b1);
    step();
    ajust = 1'b0;
    repeat (4) step();
    check_time("one_pm", 8'h01, 8'h00, 8'h00, 1'b1);

    // mode conversion with time frozen
    run = 1'b0;
    set_load(8'h03, 8'h15, 8'h00, 1'b1);
    step();
    ajust = 1'b0;
    modo24 = 1'b1;
    step();
    check_time("to24", 8'h15, 8'h15, 8'h00, 1'b1);
    modo24 = 1'b0;
    step();
    check_time("to12", 8'h03, 8'h15, 8'h00, 1'b1);

    // rejected loads
    modo24 = 1'b1;
    step();
    set_load(8'h24, 8'h00, 8'h00, 1'b0);
    step();
    ajust = 1'b0;
    check_eq("err_h24", 32'(ajust_err), 32'd1);
    check_time("keep_h24", 8'h15, 8'h15, 8'h00, 1'b1);
    step();
    check_eq("err_h24_off", 32'(ajust_err), 32'd0);
    modo24 = 1'b0;
    step();
    set_load(8'h00, 8'h10, 8'h00, 1'b0);
    step();
    ajust = 1'b0;
    check_eq("err_h12", 32'(ajust_err), 32'd1);
    check_time("keep_h12", 8'h03, 8'h15, 8'h00, 1'b1);
    step();
    set_load(8'h03, 8'h15, 8'h5A, 1'b1);
    step();
    ajust = 1'b0;
    check_eq("err_nibble", 32'(ajust_err), 32'd1);
    check_time("keep_nibble", 8'h03, 8'h15, 8'h00, 1'b1);
    step();
    check_eq("err_nibble_off", 32'(ajust_err), 32'd0);

    // load on the prescaler wrap discards that tick
    run = 1'b1; modo24 = 1'b1;
    set_load(8'h09, 8'h00, 8'h00, 1'b0);
    step();
    ajust = 1'b0;
    repeat (3) step();
    set_load(8'h10, 8'h20, 8'h30, 1'b0);
    step();
    ajust = 1'b0;
    repeat (3) step();
    check_time("wrap_hold", 8'h10, 8'h20, 8'h30, 1'b0);
    step();
    check_time("wrap_next", 8'h10, 8'h20, 8'h31, 1'b0);

    // reset mid-second
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_time("rst24", 8'h00, 8'h00, 8'h00, 1'b0);
    check_eq("rst_segundo2", 32'(segundo), 32'd0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      run   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) modo24 = ~modo24;
      ajust = ($urandom_range(0, 29) == 0);
      ajust_pm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        ajust_hora = modo24 ? to_bcd(int'($urandom_range(0, 23)))
                            : to_bcd(int'($urandom_range(1, 12)));
        ajust_min  = ($urandom_range(0, 1) == 1) ? 8'h59 : to_bcd(int'($urandom_range(0, 59)));
        ajust_seg  = to_bcd(int'($urandom_range(50, 59)));
      end else begin
        ajust_hora = 8'($urandom);
        ajust_min  = 8'($urandom);
        ajust_seg  = 8'($urandom);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reloj_hms.md
# reloj_hms

Parametrised successor to the minutes/hours clock counter. It divides the system clock to a 1 Hz time base and keeps seconds, minutes and hours as packed BCD. It supports runtime 12 h/24 h mode with AM/PM tracking, and a validated synchronous time-load port. It sits between the board clock and the 7-segment display multiplexer, and drives the blinking seconds indicator.

## Interface
- CLK_DIV, 50_000_000: system-clock cycles per second. Must be even and ≥ 2.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  1 = prescaler advances; 0 = time frozen.
- modo24  in  1  1 = 24 h display, 0 = 12 h display.
- ajust  in  1  load strobe, sampled on each rising edge.
- ajust_seg, ajust_min, ajust_hora  in  8  BCD {tens[7:4], units[3:0]} load values.
- ajust_pm  in  1  PM flag for loads in 12 h mode; ignored in 24 h mode.
- seg, min, hora  out  8  current time, packed BCD.
- pm  out  1  PM indicator, valid in both modes.
- segundo  out  1  1 Hz square wave, 50 % duty.
- tick_min  out  1  one-cycle pulse on each minute rollover.
- ajust_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset values: seg=00, min=00, pm=0, segundo=0, tick_min=0, ajust_err=0, prescaler=0. hora=00 if modo24=1 at reset, else hora=12. The mode register captures modo24.
- Prescaler counts 0..CLK_DIV-1 while run=1 and wraps to 0. The wrap cycle is the second tick.
- segundo = 1 while prescaler < CLK_DIV/2, else 0.
- Seconds count 00..59 and carry to minutes. Minutes count 00..59 and carry to hours.
- 24 h hours count 00..23, then wrap to 00. pm = (hora ≥ 12).
- 12 h hours run 12,01..11,12.
  - pm toggles on the 11→12 transition.
  - 12→01 never touches pm.
- tick_min is asserted in the same cycle that seg wraps 59→00.
- Mode change: when modo24 differs from the mode register, the hour is converted and the register updated in the same edge. Minutes and seconds are untouched.
  - 24→12: 00→12 pm0; 01..11 unchanged pm0; 12→12 pm1; 13..23→h−12 pm1.
  - 12→24: 12 pm0→00; 12 pm1→12; h pm1→h+12; h pm0→h.
- Load (ajust=1): values are validated against modo24 as sampled this cycle.
  - Every nibble must be BCD, seg ≤ 59, min ≤ 59.
  - Hour must be 00..23 in 24 h mode, 01..12 in 12 h mode.
  - Valid load: registers are written, pm = ajust_pm (12 h) or derived (24 h), the mode register is set to modo24, and the prescaler clears to 0. No conversion is applied.
  - Invalid load: time is unchanged and ajust_err pulses on the next cycle.
- Priority in one cycle: load > mode conversion > second tick. A tick that coincides with a load is discarded. A tick that coincides with a conversion is deferred one cycle: the prescaler holds at CLK_DIV-1.
- run=0: prescaler, segundo and time all hold. Loads and mode conversions still act.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- With run=1 from reset release, seg becomes 01 on the CLK_DIV-th rising edge after reset deasserts.
- Load: new values appear on the edge that samples ajust=1. The next increment occurs CLK_DIV edges later.
- Full cascade 23:59:59→00:00:00 (or 11:59:59 pm0→12:00:00 pm1) completes in one edge. tick_min is high for that single cycle.
- Reset asserted mid-second discards the partial prescaler count. Reset overrides load and conversion.

## Structure
- Package reloj_pkg:
  - bcd2_t (8-bit packed BCD) type.
  - Constants SEG_MAX=8'h59, MIN_MAX=8'h59, H24_MAX=8'h23, H12_MAX=8'h12, H12_MIN=8'h01.
  - Functions bcd_valid() and hour_convert().
- Sub-module reloj_bcd_digito: 2-digit BCD modulo counter with inputs inc, load, load_val and parameter MAX. It outputs value and a carry that is asserted when value=MAX and inc=1. Instantiate it for seconds and minutes.
- Hours, pm, the mode register, the prescaler and load validation live in the top level.

## Test plan
Run all scenarios with CLK_DIV=4.
- Reset with modo24=0, run=1 for 8 cycles → hora=12, min=00, seg=02, pm=0; segundo pattern 1,1,0,0 repeating.
- Load 24 h 23:59:58, run for 8 cycles → 23:59:59, then 00:00:00 with pm 1→0 and a single tick_min pulse.
- Load 12 h 11:59:59 pm0, tick → 12:00:00 pm=1. Load 12:59:59 pm1, tick → 01:00:00 pm=1.
- At 12 h 03:15:00 pm1, set modo24=1 → next edge hora=15, pm=1. Return modo24=0 → hora=03, pm=1.
- Loads of 24:00:00, 12 h 00:10:00 and seg=8'h5A → time unchanged, ajust_err pulses one cycle after each.
- ajust=1 on the prescaler wrap cycle with 10:20:30 → 10:20:30 held for 4 edges, then 10:20:31. Reset asserted mid-count → all outputs return to reset values on the next edge.
